// File: rtl/rv32i_pkg.sv
// Shared types and encodings for the multi-cycle RV32I core.
package rv32i_pkg;

  typedef enum logic [1:0] {
    FETCH,
    EXECUTE,
    MEM,
    HALT
  } core_state_t;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane handling for loads/stores: enables, store replication,
// load extraction/extension, and misalignment / bad-funct3 detection.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bad_funct3
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = load_word[{addr_lo, 3'b000} +: 8];
    half_sel   = load_word[{addr_lo[1], 4'b0000} +: 16];
    be         = '0;
    wdata      = '0;
    load_data  = '0;
    misaligned = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be         = 4'b0001 << addr_lo;
        wdata      = {4{store_data[7:0]}};
        load_data  = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
        bad_funct3 = is_store && (funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        load_data  = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
        misaligned = addr_lo[0];
        bad_funct3 = is_store && (funct3 == F3_HU);
      end
      F3_W: begin
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = load_word;
        misaligned = |addr_lo;
      end
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_core.sv
// Multi-cycle RV32I core: FETCH -> EXECUTE (-> MEM) over req/ack instruction
// and data ports; halts permanently on illegal or misaligned events.
module rv32i_multicycle_core #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ack,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [3:0]          dmem_be,
  output logic [31:0]         dmem_wdata,
  input  logic [31:0]         dmem_rdata,
  input  logic                dmem_ack,
  output logic [PC_WIDTH-1:0] pc,
  output logic                retire,
  output logic                halted
);
  import rv32i_pkg::*;

  core_state_t         state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [31:0]         dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
  logic [3:0]          dmem_be_q, dmem_be_d;
  logic                dmem_we_q, dmem_we_d;

  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [31:0] rf_wdata;

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [2:0]  funct3;
  logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_ext, link, ea, alu_b, alu_y, target;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic        alu_ok, br_ok, taken, illegal, jump, wr_rd, is_mem, is_store;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_wdata, lsu_load;
  logic        lsu_mis, lsu_bad;

  assign opcode = ir_q[6:0];
  assign rd_a   = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1_a  = ir_q[19:15];
  assign rs2_a  = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  assign rs1_v = (rs1_a == 5'd0) ? '0 : rf_q[rs1_a];
  assign rs2_v = (rs2_a == 5'd0) ? '0 : rf_q[rs2_a];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  assign pc_ext   = 32'(pc_q);
  assign pc_plus4 = pc_q + PC_WIDTH'(4);
  assign link     = 32'(pc_plus4);
  assign is_store = (opcode == STORE);
  // rs1 cannot change between EXECUTE and the MEM ack, so ea stays valid for load extraction.
  assign ea       = rs1_v + (is_store ? imm_s : imm_i);

  lsu_align u_lsu (
    .funct3     (funct3),
    .is_store   (is_store),
    .addr_lo    (ea[1:0]),
    .store_data (rs2_v),
    .load_word  (dmem_rdata),
    .be         (lsu_be),
    .wdata      (lsu_wdata),
    .load_data  (lsu_load),
    .misaligned (lsu_mis),
    .bad_funct3 (lsu_bad)
  );

  always_comb begin
    alu_b  = (opcode == OP) ? rs2_v : imm_i;
    alu_ok = 1'b1;
    if (opcode == OP) begin
      alu_ok = (funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
    end else if (funct3 == 3'd1) begin
      alu_ok = (funct7 == 7'h00);
    end else if (funct3 == 3'd5) begin
      alu_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
    end
    case (funct3)
      3'd0:    alu_y = (opcode == OP && ir_q[30]) ? rs1_v - alu_b : rs1_v + alu_b;
      3'd1:    alu_y = rs1_v << alu_b[4:0];
      3'd2:    alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
      3'd3:    alu_y = {31'b0, rs1_v < alu_b};
      3'd4:    alu_y = rs1_v ^ alu_b;
      3'd5:    alu_y = ir_q[30] ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'd6:    alu_y = rs1_v | alu_b;
      default: alu_y = rs1_v & alu_b;
    endcase
  end

  always_comb begin
    br_ok = 1'b1;
    case (funct3)
      F3_BEQ:  taken = (rs1_v == rs2_v);
      F3_BNE:  taken = (rs1_v != rs2_v);
      F3_BLT:  taken = ($signed(rs1_v) < $signed(rs2_v));
      F3_BGE:  taken = ($signed(rs1_v) >= $signed(rs2_v));
      F3_BLTU: taken = (rs1_v < rs2_v);
      F3_BGEU: taken = (rs1_v >= rs2_v);
      default: begin
        taken = 1'b0;
        br_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_we_d    = dmem_we_q;
    dmem_wdata_d = dmem_wdata_q;
    rf_we        = 1'b0;
    rf_wdata     = alu_y;
    retire       = 1'b0;
    illegal      = 1'b0;
    jump         = 1'b0;
    wr_rd        = 1'b0;
    is_mem       = 1'b0;
    target       = link;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        case (opcode)
          OP, OP_IMM: begin
            wr_rd   = 1'b1;
            illegal = !alu_ok;
          end
          LUI: begin
            wr_rd    = 1'b1;
            rf_wdata = imm_u;
          end
          AUIPC: begin
            wr_rd    = 1'b1;
            rf_wdata = pc_ext + imm_u;
          end
          JAL: begin
            wr_rd    = 1'b1;
            rf_wdata = link;
            jump     = 1'b1;
            target   = pc_ext + imm_j;
          end
          JALR: begin
            wr_rd    = 1'b1;
            rf_wdata = link;
            jump     = 1'b1;
            illegal  = (funct3 != 3'd0);
            target   = (rs1_v + imm_i) & ~32'd1;
          end
          BRANCH: begin
            illegal = !br_ok;
            jump    = taken;
            target  = pc_ext + imm_b;
          end
          LOAD, STORE: begin
            is_mem  = 1'b1;
            illegal = lsu_bad || lsu_mis;
          end
          default: illegal = 1'b1;
        endcase
        if (illegal || (jump && target[1:0] != 2'b00)) begin
          state_d = HALT;
        end else if (is_mem) begin
          dmem_addr_d  = {ea[31:2], 2'b00};
          dmem_be_d    = lsu_be;
          dmem_we_d    = is_store;
          dmem_wdata_d = is_store ? lsu_wdata : '0;
          state_d      = MEM;
        end else begin
          rf_we   = wr_rd;
          pc_d    = jump ? target[PC_WIDTH-1:0] : pc_plus4;
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          rf_we    = !dmem_we_q;
          rf_wdata = lsu_load;
          pc_d     = pc_plus4;
          retire   = 1'b1;
          state_d  = FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_we_q    <= 1'b0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_we_q    <= dmem_we_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we && rd_a != 5'd0) rf_q[rd_a] <= rf_wdata;
  end

  // FETCH is the reset state, so the request is masked while rst is held.
  assign imem_req   = (state_q == FETCH) && !rst;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == MEM);
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;
  assign pc         = pc_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// Directed bench for rv32i_multicycle_core: 32-bit PC core at 0x100 and an
// 8-bit PC core at 0xFC for wrap and misaligned-load halting.
module tb_rv32i_multicycle_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst8;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;
  logic [3:0]  dmem_be;
  logic [31:0] imem [0:127];
  int unsigned dwait, dcnt;

  assign imem_rdata = imem[imem_addr[8:2]];
  assign imem_ack   = imem_req;
  assign dmem_ack   = dmem_req && (dcnt >= dwait);
  initial dcnt = 0;
  always @(posedge clk) dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;

  rv32i_multicycle_core #(.PC_WIDTH(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc(pc), .retire(retire), .halted(halted)
  );

  logic        i8_req, i8_ack, d8_req, d8_we, d8_ack, retire8, halted8;
  logic [7:0]  i8_addr, pc8;
  logic [31:0] i8_rdata, d8_addr, d8_wdata, d8_rdata;
  logic [3:0]  d8_be;
  logic [31:0] imem8 [0:63];

  assign i8_rdata = imem8[i8_addr[7:2]];
  assign i8_ack   = i8_req;
  assign d8_ack   = d8_req;
  assign d8_rdata = '0;

  rv32i_multicycle_core #(.PC_WIDTH(8), .RESET_PC(8'hFC)) dut8 (
    .clk(clk), .rst(rst8),
    .imem_req(i8_req), .imem_addr(i8_addr), .imem_rdata(i8_rdata), .imem_ack(i8_ack),
    .dmem_req(d8_req), .dmem_we(d8_we), .dmem_addr(d8_addr), .dmem_be(d8_be),
    .dmem_wdata(d8_wdata), .dmem_rdata(d8_rdata), .dmem_ack(d8_ack),
    .pc(pc8), .retire(retire8), .halted(halted8)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int op, input int f3, input int rd, input int rs1, input int imm);
    logic [31:0] o, t, d, s, i;
    o = op; t = f3; d = rd; s = rs1; i = imm;
    return {i[11:0], s[4:0], t[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_s(input int f3, input int rs1, input int rs2, input int imm);
    logic [31:0] t, s, r, i;
    t = f3; s = rs1; r = rs2; i = imm;
    return {i[11:5], r[4:0], s[4:0], t[2:0], i[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
    logic [31:0] t, s, r, i;
    t = f3; s = rs1; r = rs2; i = imm;
    return {i[12], i[10:5], r[4:0], s[4:0], t[2:0], i[4:1], i[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int rd, input int imm);
    logic [31:0] d, i;
    d = rd; i = imm;
    return {i[20], i[10:1], i[11], i[19:12], d[4:0], 7'h6F};
  endfunction

  function automatic logic [31:0] enc_u(input int op, input int rd, input int imm20);
    logic [31:0] o, d, i;
    o = op; d = rd; i = imm20;
    return {i[19:0], d[4:0], o[6:0]};
  endfunction

  task automatic wait_retire(input string tag, output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!retire && n < 50);
    if (!retire) check({tag, "_timeout"}, 32'(retire), 32'd1);
  endtask

  task automatic wait_retire_at(input string tag, input logic [31:0] addr);
    int unsigned n;
    n = 0;
    while (!(retire && pc == addr) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(retire && pc == addr)) check({tag, "_timeout"}, pc, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n, k, nret, nreq;
    rst = 1'b1; rst8 = 1'b1; dwait = 0; dmem_rdata = 32'h8000_0000;
    for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0000;
    for (int i = 0; i < 64; i++) imem8[i] = 32'h0000_0000;
    imem[32'h100 >> 2] = enc_i(7'h13, 0, 1, 0, 5);
    imem[32'h104 >> 2] = enc_i(7'h13, 0, 2, 1, -7);
    imem[32'h108 >> 2] = enc_i(7'h13, 0, 1, 0, 3);
    imem[32'h10C >> 2] = enc_i(7'h13, 0, 2, 0, 3);
    imem[32'h110 >> 2] = enc_j(0, 32'h20 - 32'h110);
    imem[32'h20 >> 2]  = enc_b(0, 1, 2, 16);
    imem[32'h30 >> 2]  = enc_i(7'h13, 0, 6, 0, 32'h40);
    imem[32'h34 >> 2]  = enc_j(0, 32'h10 - 32'h34);
    imem[32'h10 >> 2]  = enc_i(7'h67, 0, 5, 6, 1);
    imem[32'h40 >> 2]  = enc_i(7'h13, 0, 1, 0, 32'h200);
    imem[32'h44 >> 2]  = enc_u(7'h37, 2, 20'hAABBD);
    imem[32'h48 >> 2]  = enc_i(7'h13, 0, 2, 2, -803);
    imem[32'h4C >> 2]  = enc_s(0, 1, 2, 3);
    imem[32'h50 >> 2]  = enc_i(7'h03, 0, 3, 1, 3);
    imem[32'h54 >> 2]  = enc_i(7'h03, 4, 4, 1, 3);
    imem[32'h58 >> 2]  = enc_i(7'h03, 2, 7, 1, 0);
    imem[32'h5C >> 2]  = enc_j(5, 2);
    imem8[63] = enc_i(7'h13, 0, 1, 0, 32'h202);
    imem8[0]  = enc_i(7'h03, 2, 2, 1, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_pc", pc, 32'h100);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_dmem_be", 32'(dmem_be), 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_dmem_wdata", dmem_wdata, 32'd0);
    rst = 1'b0;
    #1;
    check("first_fetch_req", 32'(imem_req), 32'd1);
    check("first_fetch_addr", imem_addr, 32'h100);

    // ADDI pair, 2-cycle retire cadence
    wait_retire("addi1", n);
    check("addi1_pc", pc, 32'h100);
    wait_retire("addi2", n);
    check("retire_period", n, 32'd2);
    @(negedge clk);
    check("addi_x2", dut.rf_q[2], 32'hFFFF_FFFE);

    // BEQ taken
    repeat (3) wait_retire("setup", n);
    wait_retire("beq", n);
    check("beq_pc", pc, 32'h20);
    @(negedge clk);
    check("beq_next_fetch", imem_addr, 32'h30);

    // JALR with bit 0 cleared
    repeat (2) wait_retire("setup2", n);
    wait_retire("jalr", n);
    check("jalr_pc", pc, 32'h10);
    @(negedge clk);
    check("jalr_target", pc, 32'h40);
    check("jalr_link", dut.rf_q[5], 32'h14);

    // SB lane placement
    repeat (3) wait_retire("setup3", n);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!dmem_req && k < 20);
    check("sb_req", 32'(dmem_req), 32'd1);
    check("sb_we", 32'(dmem_we), 32'd1);
    check("sb_addr", dmem_addr, 32'h200);
    check("sb_be", 32'(dmem_be), 32'h8);
    check("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);

    // LB / LBU from lane 3
    wait_retire("lb", n);
    check("lb_latency", n, 32'd3);
    @(negedge clk);
    check("lb_x3", dut.rf_q[3], 32'hFFFF_FF80);
    wait_retire("lbu", n);
    @(negedge clk);
    check("lbu_x4", dut.rf_q[4], 32'h0000_0080);

    // LW with 3 wait cycles
    check("lw_fetch_addr", imem_addr, 32'h58);
    dwait = 3;
    dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      check("lw_req", 32'(dmem_req), 32'd1);
      check("lw_addr", dmem_addr, 32'h200);
      check("lw_be", 32'(dmem_be), 32'hF);
      check("lw_we", 32'(dmem_we), 32'd0);
    end while (!retire && k < 10);
    check("lw_retire_offset", k, 32'd4);
    dwait = 0;
    @(negedge clk);
    check("lw_x7", dut.rf_q[7], 32'h1234_5678);

    // JAL to a misaligned target halts without side effects
    nret = 0;
    repeat (10) begin
      @(negedge clk);
      if (retire) nret++;
    end
    check("jal_mis_retires", nret, 32'd0);
    check("jal_mis_halted", 32'(halted), 32'd1);
    check("jal_mis_pc", pc, 32'h5C);
    check("jal_mis_imem_req", 32'(imem_req), 32'd0);
    check("jal_mis_x5", dut.rf_q[5], 32'h14);

    // BNE not taken, same operands
    imem[32'h20 >> 2] = enc_b(1, 1, 2, 16);
    rst = 1'b1;
    @(negedge clk);
    check("halt_cleared", 32'(halted), 32'd0);
    rst = 1'b0;
    wait_retire_at("bne", 32'h20);
    @(negedge clk);
    check("bne_next_fetch", imem_addr, 32'h24);

    // Reset during a stalled LW
    imem[32'h20 >> 2] = enc_b(0, 1, 2, 16);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_retire_at("to_lw", 32'h54);
    dwait = 30;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!dmem_req && k < 20);
    repeat (2) @(negedge clk);
    check("stall_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_abort_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_abort_pc", pc, 32'h100);
    @(negedge clk);
    rst = 1'b0;
    dwait = 0;

    // 8-bit PC: wrap, then misaligned LW halts
    check("pc8_rst", 32'(pc8), 32'hFC);
    @(negedge clk);
    rst8 = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!retire8 && k < 20);
    check("pc8_retire_at", 32'(pc8), 32'hFC);
    @(negedge clk);
    check("pc8_wrap", 32'(pc8), 32'h00);
    nret = 0;
    nreq = 0;
    repeat (12) begin
      @(negedge clk);
      if (retire8) nret++;
      if (d8_req) nreq++;
    end
    check("lw_mis_dmem_req", nreq, 32'd0);
    check("lw_mis_retires", nret, 32'd0);
    check("lw_mis_halted", 32'(halted8), 32'd1);
    check("lw_mis_x1", dut8.rf_q[1], 32'h202);
    check("lw_mis_pc", 32'(pc8), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
